uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 54, meaning clk cycles per oversample tick (16 ticks per bit period); legal range 2..1023.
REQ-002 SHALL provide port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL provide port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL provide port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 SHALL provide port rx_valid  output  1  byte available in rx_data.
REQ-007 SHALL provide port rx_ready  input  1  consumer accepts byte when rx_valid=1 and rx_ready=1.
REQ-008 SHALL provide port frame_err  output  1  one-cycle pulse when a stop bit samples 0.
REQ-009 SHALL provide port overrun  output  1  one-cycle pulse when a completed byte is dropped.
REQ-010 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; rx_s denotes its output; all decisions use rx_s.
REQ-012 SHALL generate tick from a counter 0..CLK_DIV-1; tick=1 on the cycle the counter equals CLK_DIV-1; counter cleared on entry to START.
REQ-013 SHALL keep a 4-bit tick count within the current bit and a 3-bit data bit index.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: on rx_s=0 SHALL enter START with tick counter, tick count and bit index cleared.
REQ-016 START: on the 8th tick (mid start bit), rx_s=1 SHALL return to IDLE (glitch, no flags); rx_s=0 SHALL enter DATA with tick count cleared.
REQ-017 DATA: on each 16th tick SHALL shift rx_s into bit[index] of the shift register, index+1; after index 7 is sampled SHALL enter STOP.
REQ-018 STOP: on the 16th tick rx_s=1 SHALL deliver the byte per REQ-020..022 and enter IDLE; rx_s=0 SHALL pulse frame_err, discard the byte, enter WAIT_HIGH.
REQ-019 WAIT_HIGH: SHALL stay until rx_s=1, then enter IDLE; no start detection while in WAIT_HIGH.
REQ-020 Delivery SHALL load rx_data and set rx_valid=1 on the cycle after the stop-bit sample when rx_valid=0, or when rx_valid=1 and rx_ready=1 on the delivery cycle (valid stays 1, new data).
REQ-021 Delivery with rx_valid=1 and rx_ready=0 SHALL keep old rx_data, keep rx_valid=1, pulse overrun for one cycle.
REQ-022 rx_valid SHALL clear the cycle after a handshake with no simultaneous delivery; rx_data SHALL not change while rx_valid=1 except per REQ-020.
REQ-023 frame_err and overrun SHALL never be asserted for more than one consecutive cycle per event.
REQ-024 rx_ready while rx_valid=0 SHALL have no effect.

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE, all counters 0, synchronizer flops 1, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
REQ-026 reset_n asserted mid-frame SHALL abandon the frame without any flag; after release a new start bit SHALL be received normally.
REQ-027 Reset release SHALL not be interpreted as a start bit while rx is high.

Verification
REQ-028 CLK_DIV=4 (64 clk/bit), rx_ready=0: send 0xA5 with stop=1 -> rx_valid=1, rx_data=8'hA5, frame_err=0, busy=0 after frame.
REQ-029 rx low for 24 clk (6 ticks) then high -> START returns to IDLE, rx_valid stays 0, no flag pulses.
REQ-030 send 0x3C with stop bit 0, rx held low 200 clk, then high -> one frame_err pulse, rx_valid=0, state WAIT_HIGH until rx high then IDLE; next 0x81 received correctly.
REQ-031 send 0x11 then 0x22, rx_ready=0 -> rx_data=8'h11, one overrun pulse; repeat with rx_ready=1 on the 0x22 delivery cycle -> rx_data=8'h22, rx_valid=1, no overrun.
REQ-032 reset_n low for 3 clk during data bit 4 of 0x55 -> all outputs reset values, no rx_valid; then send 0xF0 -> rx_data=8'hF0.
REQ-033 back-to-back frames 0x00, 0xFF with rx_ready=1 held -> two one-cycle rx_valid handshakes with correct data, no flags.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with 16x oversampling, valid/ready output and frame/overrun flags
module uart_rx_ctrl #(
  parameter int CLK_DIV = 54
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, WAIT_HIGH = 3'd4;
  localparam int DW = $clog2(CLK_DIV);
  logic [2:0] state;
  logic [DW-1:0] div;
  logic [3:0] tcnt;
  logic [2:0] bidx;
  logic [7:0] shreg;
  logic rx_m, rx_s, tick, mid, last, deliver;
  assign tick = div == DW'(CLK_DIV - 1);
  assign mid = tick && tcnt == 4'd7;
  assign last = tick && tcnt == 4'd15;
  assign deliver = state == STOP && last && rx_s;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      div <= '0;
      tcnt <= '0;
      bidx <= '0;
      shreg <= '0;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      div <= ((state == IDLE && !rx_s) || tick) ? '0 : div + 1'b1;
      if (tick) tcnt <= tcnt + 4'd1;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          tcnt <= '0;
          bidx <= '0;
        end
        START: if (mid) begin
          state <= rx_s ? IDLE : DATA;
          tcnt <= '0;
        end
        DATA: if (last) begin
          shreg[bidx] <= rx_s;
          bidx <= bidx + 3'd1;
          if (bidx == 3'd7) state <= STOP;
        end
        STOP: if (last) begin
          state <= rx_s ? IDLE : WAIT_HIGH;
          frame_err <= !rx_s;
        end
        WAIT_HIGH: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
      // a full buffer only takes the new byte if it is being drained on the same cycle
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data <= shreg;
          rx_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed checks of uart_rx_ctrl at CLK_DIV=4 (64 clk per bit)
module tb_uart_rx_ctrl;
  logic clk = 0, reset_n = 0, rx = 1, rx_ready = 0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int checks = 0, errors = 0;
  int fe_n = 0, ov_n = 0, vlow_n = 0, hs_n = 0;
  logic [7:0] hs_d [16];
  int f0, o0, v0, h0;

  uart_rx_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_n = fe_n + 1;
    if (overrun) ov_n = ov_n + 1;
    if (!rx_valid) vlow_n = vlow_n + 1;
    if (rx_valid && rx_ready && hs_n < 16) begin
      hs_d[hs_n] = rx_data;
      hs_n = hs_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack();
    @(negedge clk) rx_ready = 1;
    @(negedge clk) rx_ready = 0;
  endtask

  // start bit at c=0, data bit i from c=64*(i+1), stop from c=576 for stop_len cycles;
  // the stop bit is sampled on the edge after negedge 610, so rdy_c=610 hits the delivery cycle
  task automatic send(input logic [7:0] d, input logic stop, input int stop_len,
                      input int rdy_c, input int rst_c);
    @(negedge clk) rx = 0;
    for (int c = 1; c <= 576 + stop_len; c++) begin
      @(negedge clk);
      if (c % 64 == 0 && c <= 576) rx = (c == 576) ? stop : d[c/64-1];
      if (c == rdy_c) rx_ready = 1;
      if (c == rdy_c + 1) rx_ready = 0;
      if (c == rst_c) begin
        reset_n = 0;
        rx = 1;
        return;
      end
    end
  endtask

  task automatic snap();
    f0 = fe_n; o0 = ov_n; v0 = vlow_n; h0 = hs_n;
  endtask

  initial begin
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {frame_err, overrun}, 0);
    idle(3);
    reset_n = 1;
    idle(20);
    chk("release_busy", busy, 0);
    chk("release_valid", rx_valid, 0);

    snap();
    send(8'hA5, 1, 64, -1, -1);
    chk("a5_valid", rx_valid, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_busy", busy, 0);
    chk("a5_fe", fe_n - f0, 0);
    ack();
    chk("ack_clear", rx_valid, 0);

    snap();
    rx = 0;
    idle(10);
    chk("glitch_busy", busy, 1);
    idle(14);
    rx = 1;
    idle(100);
    chk("glitch_idle", busy, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_flags", (fe_n - f0) + (ov_n - o0), 0);

    snap();
    send(8'h3C, 0, 200, -1, -1);
    chk("fe_wait_high", busy, 1);
    chk("fe_pulse", fe_n - f0, 1);
    rx = 1;
    idle(10);
    chk("fe_idle", busy, 0);
    chk("fe_valid", rx_valid, 0);
    send(8'h81, 1, 64, -1, -1);
    chk("81_data", rx_data, 8'h81);
    chk("81_valid", rx_valid, 1);
    chk("81_fe", fe_n - f0, 1);
    ack();

    snap();
    send(8'h11, 1, 64, -1, -1);
    send(8'h22, 1, 64, -1, -1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_pulse", ov_n - o0, 1);
    snap();
    send(8'h22, 1, 64, 610, -1);
    chk("swap_data", rx_data, 8'h22);
    chk("swap_valid", rx_valid, 1);
    chk("swap_no_ovr", ov_n - o0, 0);
    chk("swap_no_gap", vlow_n - v0, 0);

    snap();
    send(8'h55, 1, 64, -1, 64 * 5 + 32);
    #1;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {frame_err, overrun}, 0);
    idle(3);
    reset_n = 1;
    idle(100);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", rx_valid, 0);
    send(8'hF0, 1, 64, -1, -1);
    chk("f0_data", rx_data, 8'hF0);
    chk("f0_valid", rx_valid, 1);
    chk("f0_flags", (fe_n - f0) + (ov_n - o0), 0);
    ack();

    snap();
    rx_ready = 1;
    send(8'h00, 1, 64, -1, -1);
    send(8'hFF, 1, 64, -1, -1);
    idle(10);
    rx_ready = 0;
    chk("b2b_hs", hs_n - h0, 2);
    chk("b2b_d0", hs_d[h0], 8'h00);
    chk("b2b_d1", hs_d[h0+1], 8'hFF);
    chk("b2b_valid", rx_valid, 0);
    chk("b2b_flags", (fe_n - f0) + (ov_n - o0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
